// File: rtl/joy_pkg.sv
// Shared definitions for the joystick conditioning path.
//   - Bit positions of the active-low joystick word.
//   - The all-released output pattern.
//   - Autofire FSM state encoding.
//   - The helper that builds a 7-bit port word.
package joy_pkg;

  localparam int JOY_RIGHT  = 0;
  localparam int JOY_LEFT   = 1;
  localparam int JOY_DOWN   = 2;
  localparam int JOY_UP     = 3;
  localparam int JOY_FIRE   = 4;
  localparam int JOY_FIRE2  = 5;
  localparam int JOY_UNUSED = 6;

  localparam int JOY_IN_W  = 6;
  localparam int JOY_OUT_W = 7;

  localparam logic [JOY_OUT_W-1:0] JOY_RELEASED = 7'h7F;

  typedef enum logic [1:0] {
    AF_IDLE = 2'd0,
    AF_ON   = 2'd1,
    AF_OFF  = 2'd2
  } af_state_e;

  // Build the core-facing word from the debounced lines. The fire bit is
  // replaced by the autofire result, and the unused bit is tied released.
  function automatic logic [JOY_OUT_W-1:0] joy_compose(
    input logic [JOY_IN_W-1:0] deb,
    input logic                fire
  );
    return {1'b1, deb[JOY_FIRE2], fire, deb[JOY_UP], deb[JOY_DOWN],
            deb[JOY_LEFT], deb[JOY_RIGHT]};
  endfunction

endpackage

// File: rtl/joy_debounce_bit.sv
// Single-line debouncer.
// A raw line has to disagree with the stable value for DEBOUNCE_CYCLES
// consecutive cycles before the stable value follows it. If the raw line
// returns to the stable value at any point, the count restarts.
//
// Ports:
//   clk     core clock
//   rst     synchronous reset, active-high
//   hold    forces the reset state (stable = 1, count = 0) while high
//   raw     raw active-low line, synchronous to clk
//   stable  debounced line
module joy_debounce_bit
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 28000
) (
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic raw,
  output logic stable
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (hold) begin
      stable_d = 1'b1;
      cnt_d    = '0;
    end else if (raw == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = raw;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/joy_conditioner.sv
// Joystick conditioner sitting between the SPI joystick reader and the
// JOYA/JOYB inputs of the core.
//   - Debounces all 12 raw lines.
//   - Adds per-port autofire on the primary fire button.
//   - Forces "released" until the reader reports valid data.
//   - Pulses `changed` for one cycle after either output word changes.
//
// Ports:
//   clk          core clock
//   rst          synchronous reset, active-high
//   in_valid     reader has produced at least one valid sample
//   joya_in      raw port A, active-low {fire2, fire, up, down, left, right}
//   joyb_in      raw port B, same mapping
//   autofire_en  [0] autofire on port A fire, [1] on port B fire
//   joya_out     conditioned port A, active-low, bit 6 tied high
//   joyb_out     conditioned port B, active-low, bit 6 tied high
//   changed      one-cycle pulse, the cycle after joya_out/joyb_out change
//
// Autofire FSM (one per port):
//   state   | meaning
//   AF_IDLE | fire passes through debounced
//   AF_ON   | burst phase, fire forced pressed (0)
//   AF_OFF  | burst phase, fire forced released (1)
module joy_conditioner
  import joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 28000,
  parameter int AUTOFIRE_DIV    = 1400000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [JOY_IN_W-1:0]  joya_in,
  input  logic [JOY_IN_W-1:0]  joyb_in,
  input  logic [1:0]           autofire_en,
  output logic [JOY_OUT_W-1:0] joya_out,
  output logic [JOY_OUT_W-1:0] joyb_out,
  output logic                 changed
);

  localparam int AF_W = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_DIV - 1);
  // The IDLE cycle that detects the press already drives fire low, so the
  // first ON phase starts counting at 1 to keep every half-period equal.
  localparam logic [AF_W-1:0] AF_FIRST = AF_W'(1);

  logic                        hold;
  logic [1:0][JOY_IN_W-1:0]    raw_all;
  logic [1:0][JOY_IN_W-1:0]    deb_all;
  logic [1:0]                  fire_out;

  assign hold    = ~in_valid;
  assign raw_all = {joyb_in, joya_in};

  for (genvar b = 0; b < 2 * JOY_IN_W; b++) begin : g_deb
    joy_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .hold   (hold),
      .raw    (raw_all[b / JOY_IN_W][b % JOY_IN_W]),
      .stable (deb_all[b / JOY_IN_W][b % JOY_IN_W])
    );
  end

  for (genvar p = 0; p < 2; p++) begin : g_af
    af_state_e        state_q, state_d;
    logic [AF_W-1:0]  cnt_q, cnt_d;
    logic             df;
    logic             en;
    logic             fire_d;

    assign df = deb_all[p][JOY_FIRE];
    assign en = autofire_en[p];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire_d  = df;
      case (state_q)
        AF_IDLE: begin
          if (en && !df) begin
            state_d = AF_ON;
            cnt_d   = AF_FIRST;
            fire_d  = 1'b0;
          end
        end
        AF_ON, AF_OFF: begin
          // Release or disable wins over the half-period wrap.
          if (df || !en) begin
            state_d = AF_IDLE;
            cnt_d   = '0;
            fire_d  = df;
          end else begin
            fire_d = (state_q == AF_OFF);
            if (cnt_q == AF_LAST) begin
              state_d = (state_q == AF_ON) ? AF_OFF : AF_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + AF_W'(1);
            end
          end
        end
        default: begin
          state_d = AF_IDLE;
          cnt_d   = '0;
        end
      endcase
      if (!in_valid) begin
        state_d = AF_IDLE;
        cnt_d   = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= AF_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end

    assign fire_out[p] = fire_d;
  end

  logic [JOY_OUT_W-1:0]   joya_q, joya_d;
  logic [JOY_OUT_W-1:0]   joyb_q, joyb_d;
  logic [2*JOY_OUT_W-1:0] prev_q, prev_d;
  logic                   changed_q, changed_d;

  always_comb begin
    joya_d    = JOY_RELEASED;
    joyb_d    = JOY_RELEASED;
    if (in_valid) begin
      joya_d = joy_compose(deb_all[0], fire_out[0]);
      joyb_d = joy_compose(deb_all[1], fire_out[1]);
    end
    prev_d    = {joya_q, joyb_q};
    changed_d = ({joya_q, joyb_q} != prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      joya_q    <= JOY_RELEASED;
      joyb_q    <= JOY_RELEASED;
      prev_q    <= {JOY_RELEASED, JOY_RELEASED};
      changed_q <= 1'b0;
    end else begin
      joya_q    <= joya_d;
      joyb_q    <= joyb_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
    end
  end

  assign joya_out = joya_q;
  assign joyb_out = joyb_q;
  assign changed  = changed_q;

endmodule

// File: tb/tb_joy_conditioner.sv
// Directed bench for joy_conditioner with DEBOUNCE_CYCLES=4, AUTOFIRE_DIV=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "tick k" means k rising edges after the input change.
module tb_joy_conditioner;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [5:0] joya_in;
  logic [5:0] joyb_in;
  logic [1:0] autofire_en;
  logic [6:0] joya_out;
  logic [6:0] joyb_out;
  logic       changed;

  int vectors;
  int miscompares;

  joy_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .AUTOFIRE_DIV    (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .joya_in     (joya_in),
    .joyb_in     (joyb_in),
    .autofire_en (autofire_en),
    .joya_out    (joya_out),
    .joyb_out    (joyb_out),
    .changed     (changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Square wave starting low at burst tick 0: 8 low, 8 high, ...
  function automatic logic [6:0] af_word(input int t);
    return (((t / 8) % 2) == 1) ? 7'h7F : 7'h6F;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; joya_in = 6'h00; joyb_in = 6'h00;
    autofire_en = 2'b00;
    idle(3);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vectors++;
      if (joya_out !== 7'h7F) begin
        $display("FAIL reset_joya tick %0d: got %h want 7f", k, joya_out); miscompares++;
      end
      vectors++;
      if (joyb_out !== 7'h7F) begin
        $display("FAIL reset_joyb tick %0d: got %h want 7f", k, joyb_out); miscompares++;
      end
      vectors++;
      if (changed !== 1'b0) begin
        $display("FAIL reset_changed tick %0d: got %b want 0", k, changed); miscompares++;
      end
    end
  endtask

  task automatic test_debounce_press();
    logic [6:0] exp_a;
    logic       exp_c;
    joya_in = 6'h3F; joyb_in = 6'h3F; in_valid = 1'b1;
    idle(8);
    joya_in = 6'h37;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a = (k >= 5) ? 7'h77 : 7'h7F;
      exp_c = (k == 6);
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL press_up tick %0d: got %h want %h", k, joya_out, exp_a); miscompares++;
      end
      vectors++;
      if (changed !== exp_c) begin
        $display("FAIL press_changed tick %0d: got %b want %b", k, changed, exp_c); miscompares++;
      end
    end
  endtask

  task automatic test_glitch();
    joyb_in = 6'h3E;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 3) joyb_in = 6'h3F;
      vectors++;
      if (joyb_out !== 7'h7F) begin
        $display("FAIL glitch_joyb tick %0d: got %h want 7f", k, joyb_out); miscompares++;
      end
      vectors++;
      if (changed !== 1'b0) begin
        $display("FAIL glitch_changed tick %0d: got %b want 0", k, changed); miscompares++;
      end
    end
    joya_in = 6'h3F;
    idle(8);
    vectors++;
    if (joya_out !== 7'h7F) begin
      $display("FAIL release_up: got %h want 7f", joya_out); miscompares++;
    end
  endtask

  task automatic test_both_ports();
    logic [6:0] exp_o;
    logic       exp_c;
    joya_in = 6'h3E; joyb_in = 6'h3E;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_o = (k >= 5) ? 7'h7E : 7'h7F;
      exp_c = (k == 6);
      vectors++;
      if ({joya_out, joyb_out} !== {exp_o, exp_o}) begin
        $display("FAIL both_outs tick %0d: got %h/%h want %h", k, joya_out, joyb_out, exp_o);
        miscompares++;
      end
      vectors++;
      if (changed !== exp_c) begin
        $display("FAIL both_changed tick %0d: got %b want %b", k, changed, exp_c); miscompares++;
      end
    end
    joya_in = 6'h3F; joyb_in = 6'h3F;
    idle(8);
  endtask

  task automatic test_autofire();
    logic [6:0] exp_a;
    autofire_en = 2'b01;
    joya_in = 6'h2F;
    for (int k = 1; k <= 49; k++) begin
      tick();
      if (k == 44) joya_in = 6'h3F;
      if (k < 5)        exp_a = 7'h7F;
      else if (k <= 48) exp_a = af_word(k - 5);
      else              exp_a = 7'h7F;
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL autofire tick %0d: got %h want %h", k, joya_out, exp_a); miscompares++;
      end
    end
    idle(4);
  endtask

  task automatic test_af_disable();
    logic [6:0] exp_a;
    joya_in = 6'h2F; autofire_en = 2'b01;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 14) autofire_en = 2'b00;
      if (k < 5)        exp_a = 7'h7F;
      else if (k <= 14) exp_a = af_word(k - 5);
      else              exp_a = 7'h6F;
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL af_disable tick %0d: got %h want %h", k, joya_out, exp_a); miscompares++;
      end
    end
    autofire_en = 2'b01;
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp_a = af_word(j - 1);
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL af_restart tick %0d: got %h want %h", j, joya_out, exp_a); miscompares++;
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [6:0] exp_a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({joya_out, joyb_out, changed} !== {7'h7F, 7'h7F, 1'b0}) begin
      $display("FAIL rst_burst: got %h/%h/%b want 7f/7f/0", joya_out, joyb_out, changed);
      miscompares++;
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_a = (k == 5) ? 7'h6F : 7'h7F;
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL rst_recover tick %0d: got %h want %h", k, joya_out, exp_a); miscompares++;
      end
    end
    joya_in = 6'h3F; autofire_en = 2'b00;
    idle(8);
  endtask

  task automatic test_port_b_autofire();
    logic [6:0] exp_b;
    autofire_en = 2'b10;
    joyb_in = 6'h2F;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp_b = (k < 5) ? 7'h7F : af_word(k - 5);
      vectors++;
      if (joyb_out !== exp_b) begin
        $display("FAIL b_autofire tick %0d: got %h want %h", k, joyb_out, exp_b); miscompares++;
      end
      vectors++;
      if (joya_out !== 7'h7F) begin
        $display("FAIL b_autofire_a tick %0d: got %h want 7f", k, joya_out); miscompares++;
      end
    end
    joyb_in = 6'h3F; autofire_en = 2'b00;
    idle(8);
  endtask

  task automatic test_in_valid_drop();
    logic [6:0] exp_a;
    joya_in = 6'h37;
    idle(6);
    vectors++;
    if (joya_out !== 7'h77) begin
      $display("FAIL valid_pre: got %h want 77", joya_out); miscompares++;
    end
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      vectors++;
      if (joya_out !== 7'h7F) begin
        $display("FAIL valid_low tick %0d: got %h want 7f", k, joya_out); miscompares++;
      end
    end
    in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_a = (k == 5) ? 7'h77 : 7'h7F;
      vectors++;
      if (joya_out !== exp_a) begin
        $display("FAIL valid_rise tick %0d: got %h want %h", k, joya_out, exp_a); miscompares++;
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; in_valid = 1'b0; joya_in = 6'h00; joyb_in = 6'h00; autofire_en = 2'b00;
    test_reset();
    test_debounce_press();
    test_glitch();
    test_both_ports();
    test_autofire();
    test_af_disable();
    test_reset_mid_burst();
    test_port_b_autofire();
    test_in_valid_drop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_conditioner.md
Name: joy_conditioner

Overview:
- Conditions joystick inputs after the MCP23S17 SPI joystick reader and before the JOYA/JOYB inputs of the Minimig core.
- Debounces all 12 raw joystick lines and generates per-port autofire on the primary fire button.
- Forces the "released" pattern until the reader reports valid data.
- Raises a one-cycle change strobe for OSD/host polling.

Parameters:
DEBOUNCE_CYCLES, 28000, cycles a raw bit must differ from its stable value before the stable value is updated (about 1 ms at 28 MHz); minimum 2.
AUTOFIRE_DIV, 1400000, cycles per autofire half-period (10 Hz at 28 MHz); minimum 2.

Ports:
clk  input  1  core clock (clk_28 domain).
rst  input  1  synchronous reset, active-high.
in_valid  input  1  reader has completed at least one SPI read; inputs are meaningful.
joya_in  input  6  raw port A, active-low: [5]fire2 [4]fire [3]up [2]down [1]left [0]right; synchronous to clk.
joyb_in  input  6  raw port B, same bit mapping.
autofire_en  input  2  [0] enables autofire on port A fire, [1] on port B fire; level input.
joya_out  output  7  conditioned port A, active-low; bit 6 is always 1.
joyb_out  output  7  conditioned port B, active-low; bit 6 is always 1.
changed  output  1  one-cycle pulse, asserted the cycle after joya_out or joyb_out changes value.

Behaviour:
- Reset:
  - joya_out = joyb_out = 7'h7F; changed = 0.
  - All stable bits = 1; all counters = 0; both autofire FSMs in IDLE.
- Outputs are registered. No combinational path exists from inputs to outputs.
- Debounce (per bit, 12 instances):
  - If raw == stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and raw still differs, stable <= raw and the counter clears.
- Debounce latency:
  - A clean raw edge reaches stable exactly DEBOUNCE_CYCLES cycles after the raw change.
  - The output register adds 1 further cycle.
- A glitch shorter than DEBOUNCE_CYCLES is ignored. Any return to the stable value restarts the count.
- While in_valid = 0:
  - Debouncers are held in their reset state (stable = 1, counter = 0).
  - Autofire FSMs are held in IDLE.
  - Outputs are 7'h7F.
- Rising edge of in_valid: debouncing starts from "all released". A held button therefore appears DEBOUNCE_CYCLES+1 cycles later.
- Autofire FSM (per port; df = debounced fire bit, 0 = pressed):
  - IDLE: fire_out = df.
    - If autofire_en && df == 0: go to ON, fire_out = 0, load the half-period counter.
  - ON: fire_out = 0. When the counter reaches AUTOFIRE_DIV-1: go to OFF, counter = 0.
  - OFF: fire_out = 1. When the counter reaches AUTOFIRE_DIV-1: go to ON, counter = 0.
  - From ON or OFF: if df == 1 (released) or autofire_en == 0, go to IDLE the same cycle and fire_out follows df.
  - The release check has priority over the counter wrap.
- Resulting autofire waveform: a sustained press gives a square wave of period 2*AUTOFIRE_DIV, starting low (pressed) immediately.
- Autofire applies only to bit 4. fire2 and the directions always pass through debounced.
- Port output composition: out = {1'b1, d5, fire_out, d3, d2, d1, d0}.
- changed: registered compare of the current vs previous {joya_out, joyb_out}. Simultaneous changes on both ports give a single pulse.
- rst asserted mid-debounce or mid-burst: all state returns to reset values on the next edge. No partial counts survive.
- Counter widths are clog2 of the respective parameter. The counters never wrap past their terminal value.

Decomposition:
- Package joy_pkg:
  - Bit index constants JOY_RIGHT=0, JOY_LEFT=1, JOY_DOWN=2, JOY_UP=3, JOY_FIRE=4, JOY_FIRE2=5, JOY_UNUSED=6.
  - JOY_RELEASED = 7'h7F.
  - Autofire state encoding: AF_IDLE, AF_ON, AF_OFF.
- Sub-module joy_debounce_bit:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, hold, raw, stable.
  - Instantiated 12 times.
- The autofire FSM is coded as a generate loop over the 2 ports in the top module.

Test Plan (DEBOUNCE_CYCLES=4, AUTOFIRE_DIV=8 for simulation):
- Reset with in_valid=0 and joya_in=6'h00 -> joya_out=joyb_out=7'h7F held; changed stays 0.
- in_valid=1, joya_in goes 6'h3F->6'h37 (up pressed) -> joya_out = 7'h77 exactly 5 cycles later; changed pulses once on the following cycle.
- joyb_in bit 0 pulses low for 3 cycles then returns high -> joyb_out stays 7'h7F; changed never asserts.
- autofire_en=2'b01, port A fire held low for 40 cycles after debounce -> joya_out[4] toggles 0 for 8 cycles, 1 for 8 cycles, and so on. On release, joya_out[4] = 1 within 5 cycles of the raw release. Bit 6 stays 1 throughout.
- Mid-burst, during OFF, drop autofire_en -> joya_out[4] returns to 0 (held) on the next cycle. Re-raising autofire_en restarts the burst in ON.
- Assert rst for 1 cycle mid-burst with in_valid=1 -> outputs read 7'h7F next cycle. The held fire reappears after the full debounce latency of 5 cycles.
